// File: rtl/pc_fetch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer_pkg
// Shared definitions for the instruction fetch sequencer:
//   - fetch FSM state encoding (IDLE, REQ, WAIT, DROP)
//   - default sequential PC increment
//   - redirect-source enumeration used by the next-PC priority mux
// ---------------------------------------------------------------------------
package pc_fetch_sequencer_pkg;

  // Fetch FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;  // one quiet cycle after reset
  localparam logic [1:0] ST_REQ  = 2'd1;  // presenting a request, waiting for grant
  localparam logic [1:0] ST_WAIT = 2'd2;  // granted, waiting for rvalid
  localparam logic [1:0] ST_DROP = 2'd3;  // granted fetch was redirected; discard its response

  // Sequential increment in bytes
  localparam int unsigned PC_INC_C = 4;

  // Source of a control-flow redirect, lowest to highest priority
  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_BRANCH = 2'd1,
    REDIR_JUMP   = 2'd2,
    REDIR_EXC    = 2'd3
  } redir_src_e;

endpackage

// File: rtl/pc_fetch_sequencer_next_select.sv
// ---------------------------------------------------------------------------
// pc_next_select
// Combinational priority mux for control-flow redirects.
// Priority: exception > jump > taken branch. The selected target is forced
// to word alignment.
// Ports:
//   exc_i, jump_i, branch_taken_i  redirect requests
//   jump_target_i, branch_target_i candidate targets
//   redirect_o                     any redirect requested this cycle
//   target_o                       word-aligned redirect target
// ---------------------------------------------------------------------------
module pc_next_select
  import pc_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        exc_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        redirect_o,
  output logic [31:0] target_o
);

  redir_src_e  src;
  logic [31:0] raw_target;

  always_comb begin
    src        = REDIR_NONE;
    raw_target = 32'h0;
    if (exc_i) begin
      src        = REDIR_EXC;
      raw_target = EXC_VECTOR;
    end else if (jump_i) begin
      src        = REDIR_JUMP;
      raw_target = jump_target_i;
    end else if (branch_taken_i) begin
      src        = REDIR_BRANCH;
      raw_target = branch_target_i;
    end
  end

  assign redirect_o = (src != REDIR_NONE);
  assign target_o   = raw_target & ~32'h0000_0003;

endmodule

// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
// Owns the architectural PC and sequences instruction fetch with a single
// outstanding memory request. Fetched instructions are held in a one-entry
// delivery buffer at the IF/ID boundary.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   stall_i                        IF/ID hold
//   exc_i / jump_i / branch_taken_i redirect requests (+ targets)
//   imem_req_o, imem_addr_o        fetch request and word address
//   imem_gnt_i                     request accepted
//   imem_rvalid_i, imem_rdata_i    fetch response
//   if_valid_o, if_instr_o         delivered instruction
//   if_pc_o, if_pc_plus4_o         its PC and PC + increment
//   flush_o                        one-cycle pulse after a redirect
// ---------------------------------------------------------------------------
module pc_fetch_sequencer
  import pc_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080,
  parameter int unsigned PC_INC     = PC_INC_C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        exc_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_pc_plus4_o,
  output logic        flush_o
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_pc_plus4_q, if_pc_plus4_d;
  logic        flush_q, flush_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_plus_inc;
  logic        fetch_done;

  pc_next_select #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_next_select (
    .exc_i           (exc_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .redirect_o      (redirect),
    .target_o        (redirect_target)
  );

  // Modulo-2^32 increment: 0xFFFF_FFFC wraps to 0.
  assign pc_plus_inc = pc_q + PC_INC;

  // Hold off new requests while a delivered instruction is still stalled in
  // the buffer; otherwise the response could overwrite it.
  assign imem_req_o  = (state_q == ST_REQ) && !(stall_i && if_valid_q);
  assign imem_addr_o = pc_q;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    if_valid_d    = if_valid_q;
    if_instr_d    = if_instr_q;
    if_pc_d       = if_pc_q;
    if_pc_plus4_d = if_pc_plus4_q;
    flush_d       = redirect;
    fetch_done    = 1'b0;

    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        // Redirect without grant simply stays in REQ with the new pc.
        if (imem_req_o && imem_gnt_i) begin
          state_d = redirect ? ST_DROP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          // A response landing with a redirect belongs to the old path.
          state_d    = ST_REQ;
          fetch_done = !redirect;
        end else if (redirect) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (imem_rvalid_i) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (redirect) begin
      pc_d = redirect_target;
    end else if (fetch_done) begin
      pc_d = pc_plus_inc;
    end

    // Delivery buffer: redirect kills, fill wins over consume, consume on !stall.
    if (redirect) begin
      if_valid_d = 1'b0;
    end else if (fetch_done) begin
      if_valid_d    = 1'b1;
      if_instr_d    = imem_rdata_i;
      if_pc_d       = pc_q;
      if_pc_plus4_d = pc_plus_inc;
    end else if (!stall_i) begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_instr_q    <= 32'h0;
      if_pc_q       <= 32'h0;
      if_pc_plus4_q <= 32'h0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_instr_q    <= if_instr_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      flush_q       <= flush_d;
    end
  end

  assign if_valid_o    = if_valid_q;
  assign if_instr_o    = if_instr_q;
  assign if_pc_o       = if_pc_q;
  assign if_pc_plus4_o = if_pc_plus4_q;
  assign flush_o       = flush_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_sequencer
// Directed bench for pc_fetch_sequencer. A small memory responder grants
// every request and returns rvalid a programmable number of cycles later;
// instruction data is a fixed function of the fetch address.
// ---------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        stall_i;
  logic        exc_i;
  logic        jump_i;
  logic [31:0] jump_target_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc_plus4_o;
  logic        flush_o;

  int checks = 0;
  int errors = 0;

  // memory responder state
  logic        granted;
  logic [31:0] gaddr;
  logic        pend;
  int          cnt;
  int          lat;
  logic [31:0] paddr;

  pc_fetch_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .exc_i           (exc_i),
    .jump_i          (jump_i),
    .jump_target_i   (jump_target_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .if_valid_o      (if_valid_o),
    .if_instr_o      (if_instr_o),
    .if_pc_o         (if_pc_o),
    .if_pc_plus4_o   (if_pc_plus4_o),
    .flush_o         (flush_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("check %s got=%h ok", tag, got);
    end
  endtask

  // Advance one clock; memory responder reacts to the grant seen before the edge.
  task automatic tick();
    @(negedge clk);
    granted = imem_req_o && imem_gnt_i;
    gaddr   = imem_addr_o;
    @(posedge clk);
    #1;
    exc_i          = 1'b0;
    jump_i         = 1'b0;
    branch_taken_i = 1'b0;
    imem_rvalid_i  = 1'b0;
    if (granted) begin
      pend  = 1'b1;
      cnt   = lat;
      paddr = gaddr;
    end else if (pend) begin
      cnt = cnt - 1;
    end
    if (pend && cnt == 1) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = instr_of(paddr);
      pend          = 1'b0;
    end
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; stall_i = 1'b0; exc_i = 1'b0; jump_i = 1'b0; branch_taken_i = 1'b0;
    jump_target_i = 32'h0; branch_target_i = 32'h0; imem_gnt_i = 1'b1;
    imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    granted = 1'b0; gaddr = 32'h0; pend = 1'b0; cnt = 0; lat = 1; paddr = 32'h0;

    // ---- reset state
    tick(); tick();
    settle();
    check_eq("rst_req",   {31'h0, imem_req_o}, 32'h0);
    check_eq("rst_addr",  imem_addr_o, 32'h0);
    check_eq("rst_valid", {31'h0, if_valid_o}, 32'h0);
    check_eq("rst_instr", if_instr_o, 32'h0);
    check_eq("rst_pc",    if_pc_o, 32'h0);
    check_eq("rst_pc4",   if_pc_plus4_o, 32'h0);
    check_eq("rst_flush", {31'h0, flush_o}, 32'h0);
    rst_n = 1'b1;
    settle();
    check_eq("idle_req", {31'h0, imem_req_o}, 32'h0);

    // ---- sequential fetch 0x0, 0x4, 0x8
    tick(); settle();
    check_eq("seq_req0",  {31'h0, imem_req_o}, 32'h1);
    check_eq("seq_addr0", imem_addr_o, 32'h0);
    tick(); settle();
    check_eq("seq_wait_req", {31'h0, imem_req_o}, 32'h0);
    tick(); settle();
    check_eq("seq_valid0", {31'h0, if_valid_o}, 32'h1);
    check_eq("seq_pc0",    if_pc_o, 32'h0);
    check_eq("seq_instr0", if_instr_o, 32'hFFFF_0000);
    check_eq("seq_pc4_0",  if_pc_plus4_o, 32'h4);
    check_eq("seq_addr1",  imem_addr_o, 32'h4);
    tick(); tick(); settle();
    check_eq("seq_pc1",   if_pc_o, 32'h4);
    check_eq("seq_addr2", imem_addr_o, 32'h8);
    tick(); tick(); settle();
    check_eq("seq_pc2",    if_pc_o, 32'h8);
    check_eq("seq_instr2", if_instr_o, 32'hFFF7_0008);

    // ---- stall 3 cycles with full buffer
    stall_i = 1'b1; settle();
    check_eq("stall_req0", {31'h0, imem_req_o}, 32'h0);
    for (int i = 1; i < 3; i++) begin
      tick(); settle();
      check_eq("stall_valid", {31'h0, if_valid_o}, 32'h1);
      check_eq("stall_pc",    if_pc_o, 32'h8);
      check_eq("stall_instr", if_instr_o, 32'hFFF7_0008);
      check_eq("stall_req",   {31'h0, imem_req_o}, 32'h0);
    end
    tick(); stall_i = 1'b0; settle();
    check_eq("resume_req",  {31'h0, imem_req_o}, 32'h1);
    check_eq("resume_addr", imem_addr_o, 32'hC);
    tick(); tick(); settle();
    check_eq("resume_pc", if_pc_o, 32'hC);
    check_eq("next_addr", imem_addr_o, 32'h10);

    // ---- branch taken while in WAIT, in-flight response dropped
    lat = 2;
    tick();
    branch_taken_i = 1'b1; branch_target_i = 32'h100; settle();
    check_eq("br_flush_pre", {31'h0, flush_o}, 32'h0);
    tick(); settle();
    check_eq("br_flush", {31'h0, flush_o}, 32'h1);
    check_eq("br_valid", {31'h0, if_valid_o}, 32'h0);
    check_eq("br_drop_req", {31'h0, imem_req_o}, 32'h0);
    check_eq("br_stale_rv", {31'h0, imem_rvalid_i}, 32'h1);
    tick(); settle();
    check_eq("br_flush_end", {31'h0, flush_o}, 32'h0);
    check_eq("br_valid2",    {31'h0, if_valid_o}, 32'h0);
    check_eq("br_req",       {31'h0, imem_req_o}, 32'h1);
    check_eq("br_addr",      imem_addr_o, 32'h100);
    lat = 1;
    tick(); tick(); settle();
    check_eq("br_pc",    if_pc_o, 32'h100);
    check_eq("br_pc4",   if_pc_plus4_o, 32'h104);
    check_eq("br_instr", if_instr_o, 32'hFEFF_0100);

    // ---- exc + jump + branch together, same cycle as a grant
    exc_i = 1'b1; jump_i = 1'b1; jump_target_i = 32'h200;
    branch_taken_i = 1'b1; branch_target_i = 32'h300;
    tick(); settle();
    check_eq("exc_flush", {31'h0, flush_o}, 32'h1);
    check_eq("exc_valid", {31'h0, if_valid_o}, 32'h0);
    check_eq("exc_pc",    imem_addr_o, 32'h80);
    tick(); settle();
    check_eq("exc_flush_once", {31'h0, flush_o}, 32'h0);
    check_eq("exc_req",        {31'h0, imem_req_o}, 32'h1);
    check_eq("exc_addr",       imem_addr_o, 32'h80);
    tick(); tick(); settle();
    check_eq("exc_if_pc", if_pc_o, 32'h80);

    // ---- jump to unaligned 0x203 in REQ without grant
    imem_gnt_i = 1'b0; jump_i = 1'b1; jump_target_i = 32'h203;
    tick(); imem_gnt_i = 1'b1; settle();
    check_eq("jmp_flush", {31'h0, flush_o}, 32'h1);
    check_eq("jmp_req",   {31'h0, imem_req_o}, 32'h1);
    check_eq("jmp_addr",  imem_addr_o, 32'h200);
    tick(); tick(); settle();
    check_eq("jmp_if_pc", if_pc_o, 32'h200);
    check_eq("jmp_pc4",   if_pc_plus4_o, 32'h204);

    // ---- wrap at top of address space
    imem_gnt_i = 1'b0; jump_i = 1'b1; jump_target_i = 32'hFFFF_FFFF;
    tick(); imem_gnt_i = 1'b1; settle();
    check_eq("wrap_addr_top", imem_addr_o, 32'hFFFF_FFFC);
    tick(); tick(); settle();
    check_eq("wrap_if_pc", if_pc_o, 32'hFFFF_FFFC);
    check_eq("wrap_pc4",   if_pc_plus4_o, 32'h0);
    check_eq("wrap_addr",  imem_addr_o, 32'h0);

    // ---- reset while WAIT, stale rvalid during IDLE
    lat = 2;
    tick(); rst_n = 1'b0;
    tick(); rst_n = 1'b1; settle();
    check_eq("rr_stale_rv", {31'h0, imem_rvalid_i}, 32'h1);
    check_eq("rr_idle_req", {31'h0, imem_req_o}, 32'h0);
    check_eq("rr_valid",    {31'h0, if_valid_o}, 32'h0);
    lat = 1;
    tick(); settle();
    check_eq("rr_valid2", {31'h0, if_valid_o}, 32'h0);
    check_eq("rr_req",    {31'h0, imem_req_o}, 32'h1);
    check_eq("rr_addr",   imem_addr_o, 32'h0);
    tick(); settle();
    check_eq("rr_valid3", {31'h0, if_valid_o}, 32'h0);
    tick(); settle();
    check_eq("rr_valid4", {31'h0, if_valid_o}, 32'h1);
    check_eq("rr_pc",     if_pc_o, 32'h0);
    check_eq("rr_instr",  if_instr_o, 32'hFFFF_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
